// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetcher and load/store buffer onto
// a synchronous 8-bit RAM/IO bus; multi-byte transfers are assembled little-endian.
module mem_ctrl #(
   parameter logic [1:0] IO_HI     = 2'b11,
   parameter int         MAX_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        if_start_signal,
   input  logic [31:0] if_pc,
   output logic        if_finish_signal,
   output logic [31:0] if_inst,
   input  logic        ls_start_signal,
   input  logic        ls_wr,
   input  logic [2:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_finish_signal,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   localparam int CW = $clog2(MAX_BYTES + 2);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t         state_q, state_d;
   logic           pending_if_q, pending_if_d;
   logic           pending_ls_q, pending_ls_d;
   logic [31:0]    if_pc_q, if_pc_d;
   logic           ls_wr_q, ls_wr_d;
   logic [2:0]     ls_size_q, ls_size_d;
   logic [31:0]    ls_addr_q, ls_addr_d;
   logic [31:0]    ls_wdata_q, ls_wdata_d;
   logic [31:0]    xfer_addr_q, xfer_addr_d;
   logic [31:0]    xfer_wdata_q, xfer_wdata_d;
   logic [CW-1:0]  xfer_n_q, xfer_n_d;
   logic           xfer_if_q, xfer_if_d;
   logic [CW-1:0]  stage_q, stage_d;
   logic [31:0]    buf_q, buf_d;
   logic           if_finish_q, if_finish_d;
   logic [31:0]    if_inst_q, if_inst_d;
   logic           ls_finish_q, ls_finish_d;
   logic [31:0]    ls_rdata_q, ls_rdata_d;
   logic [31:0]    mem_a_q, mem_a_d;
   logic [7:0]     mem_dout_q, mem_dout_d;
   logic           mem_wr_q, mem_wr_d;

   logic           ls_io_stall;
   logic [1:0]     rd_idx;
   logic [31:0]    offset;

   assign ls_io_stall = ls_wr_q && (ls_addr_q[17:16] == IO_HI) && io_buffer_full;

   // stage_q counts edges since selection; read byte k lands two edges after its address
   always_comb begin
      state_d      = state_q;
      pending_if_d = pending_if_q;
      pending_ls_d = pending_ls_q;
      if_pc_d      = if_pc_q;
      ls_wr_d      = ls_wr_q;
      ls_size_d    = ls_size_q;
      ls_addr_d    = ls_addr_q;
      ls_wdata_d   = ls_wdata_q;
      xfer_addr_d  = xfer_addr_q;
      xfer_wdata_d = xfer_wdata_q;
      xfer_n_d     = xfer_n_q;
      xfer_if_d    = xfer_if_q;
      stage_d      = stage_q;
      buf_d        = buf_q;
      if_finish_d  = 1'b0;
      if_inst_d    = if_inst_q;
      ls_finish_d  = 1'b0;
      ls_rdata_d   = ls_rdata_q;
      mem_a_d      = mem_a_q;
      mem_dout_d   = mem_dout_q;
      mem_wr_d     = mem_wr_q;
      rd_idx       = 2'(stage_q - CW'(2));
      offset       = 32'(stage_q);

      if (if_start_signal) begin
         pending_if_d = 1'b1;
         if_pc_d      = if_pc;
      end else if (rollback) begin
         pending_if_d = 1'b0;
      end
      if (ls_start_signal) begin
         pending_ls_d = 1'b1;
         ls_wr_d      = ls_wr;
         ls_size_d    = ls_size;
         ls_addr_d    = ls_addr;
         ls_wdata_d   = ls_wdata;
      end

      case (state_q)
         IDLE: begin
            mem_wr_d = 1'b0;
            if (pending_ls_q && !ls_io_stall) begin
               pending_ls_d = ls_start_signal;
               xfer_addr_d  = ls_addr_q;
               xfer_wdata_d = ls_wdata_q;
               xfer_n_d     = CW'(ls_size_q);
               xfer_if_d    = 1'b0;
               stage_d      = CW'(1);
               buf_d        = '0;
               mem_a_d      = ls_addr_q;
               if (ls_wr_q) begin
                  mem_dout_d = ls_wdata_q[7:0];
                  mem_wr_d   = 1'b1;
                  state_d    = WRITE;
               end else begin
                  state_d = READ;
               end
            end else if (pending_if_q && !rollback) begin
               pending_if_d = if_start_signal;
               xfer_addr_d  = if_pc_q;
               xfer_n_d     = CW'(MAX_BYTES);
               xfer_if_d    = 1'b1;
               stage_d      = CW'(1);
               buf_d        = '0;
               mem_a_d      = if_pc_q;
               state_d      = READ;
            end
         end
         READ: begin
            if (xfer_if_q && rollback) begin
               state_d = IDLE;
            end else begin
               if (stage_q < xfer_n_q) begin
                  mem_a_d = xfer_addr_q + offset;
               end
               if (stage_q >= CW'(2)) begin
                  buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
               end
               if (stage_q == xfer_n_q + CW'(1)) begin
                  state_d = IDLE;
                  if (xfer_if_q) begin
                     if_inst_d   = buf_d;
                     if_finish_d = 1'b1;
                  end else begin
                     ls_rdata_d  = buf_d;
                     ls_finish_d = 1'b1;
                  end
               end
               stage_d = stage_q + CW'(1);
            end
         end
         WRITE: begin
            if (stage_q < xfer_n_q) begin
               mem_a_d    = xfer_addr_q + offset;
               mem_dout_d = xfer_wdata_q[{stage_q[1:0], 3'b000} +: 8];
               mem_wr_d   = 1'b1;
               stage_d    = stage_q + CW'(1);
            end else begin
               mem_wr_d    = 1'b0;
               ls_finish_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // rdy low freezes every register, including request capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pending_if_q <= 1'b0;
         pending_ls_q <= 1'b0;
         if_pc_q      <= '0;
         ls_wr_q      <= 1'b0;
         ls_size_q    <= '0;
         ls_addr_q    <= '0;
         ls_wdata_q   <= '0;
         xfer_addr_q  <= '0;
         xfer_wdata_q <= '0;
         xfer_n_q     <= '0;
         xfer_if_q    <= 1'b0;
         stage_q      <= '0;
         buf_q        <= '0;
         if_finish_q  <= 1'b0;
         if_inst_q    <= '0;
         ls_finish_q  <= 1'b0;
         ls_rdata_q   <= '0;
         mem_a_q      <= '0;
         mem_dout_q   <= '0;
         mem_wr_q     <= 1'b0;
      end else if (rdy) begin
         state_q      <= state_d;
         pending_if_q <= pending_if_d;
         pending_ls_q <= pending_ls_d;
         if_pc_q      <= if_pc_d;
         ls_wr_q      <= ls_wr_d;
         ls_size_q    <= ls_size_d;
         ls_addr_q    <= ls_addr_d;
         ls_wdata_q   <= ls_wdata_d;
         xfer_addr_q  <= xfer_addr_d;
         xfer_wdata_q <= xfer_wdata_d;
         xfer_n_q     <= xfer_n_d;
         xfer_if_q    <= xfer_if_d;
         stage_q      <= stage_d;
         buf_q        <= buf_d;
         if_finish_q  <= if_finish_d;
         if_inst_q    <= if_inst_d;
         ls_finish_q  <= ls_finish_d;
         ls_rdata_q   <= ls_rdata_d;
         mem_a_q      <= mem_a_d;
         mem_dout_q   <= mem_dout_d;
         mem_wr_q     <= mem_wr_d;
      end
   end

   assign if_finish_signal = if_finish_q;
   assign if_inst          = if_inst_q;
   assign ls_finish_signal = ls_finish_q;
   assign ls_rdata         = ls_rdata_q;
   assign mem_a            = mem_a_q;
   assign mem_dout         = mem_dout_q;
   assign mem_wr           = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array reference model predicts every
// fetch/load/store result, a negedge monitor checks each finish pulse.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rollback;
   logic        if_start_signal;
   logic [31:0] if_pc;
   logic        if_finish_signal;
   logic [31:0] if_inst;
   logic        ls_start_signal;
   logic        ls_wr;
   logic [2:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_finish_signal;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .if_start_signal(if_start_signal), .if_pc(if_pc),
      .if_finish_signal(if_finish_signal), .if_inst(if_inst),
      .ls_start_signal(ls_start_signal), .ls_wr(ls_wr), .ls_size(ls_size),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_finish_signal(ls_finish_signal), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5a;
   endfunction

   // ram is the bus-side memory the DUT talks to; ref_mem is the model's view
   logic [7:0] ram [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n);
      logic [31:0] d = '0;
      for (int i = 0; i < n; i++) d[8*i +: 8] = ref_rd(addr + 32'(i));
      return d;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram[a] = b;
      ref_mem[a] = b;
   endtask

   always @(posedge clk) begin
      if (rdy) begin
         if (mem_wr) ram[mem_a] = mem_dout;
         mem_din <= ram_rd(mem_a);
      end
   end

   typedef struct {
      bit          is_store;
      logic [31:0] addr;
      int          n;
      logic [31:0] data;
   } ls_txn_t;

   ls_txn_t     ls_q[$];
   logic [31:0] if_q[$];
   int          if_pulses = 0;
   int          ls_pulses = 0;
   logic        last_rdy = 1'b0;

   always @(posedge clk) last_rdy <= rdy;

   // a finish is fresh only if the edge that produced it had rdy high
   always @(negedge clk) begin
      ls_txn_t     t;
      logic [31:0] act;
      if (!rst && last_rdy) begin
         check_output("finish_overlap", 32'(if_finish_signal & ls_finish_signal), 0);
         if (if_finish_signal) begin
            if_pulses++;
            check_output("if_finish_expected", 32'(if_q.size() != 0), 1);
            if (if_q.size() != 0) check_output("if_inst", if_inst, if_q.pop_front());
         end
         if (ls_finish_signal) begin
            ls_pulses++;
            check_output("ls_finish_expected", 32'(ls_q.size() != 0), 1);
            if (ls_q.size() != 0) begin
               t = ls_q.pop_front();
               if (t.is_store) begin
                  act = '0;
                  for (int i = 0; i < t.n; i++) act[8*i +: 8] = ram_rd(t.addr + 32'(i));
                  check_output("store_bytes", act, t.data);
               end else begin
                  check_output("ls_rdata", ls_rdata, t.data);
               end
            end
         end
      end
   end

   task automatic pulse_if(input logic [31:0] pc);
      @(negedge clk);
      if_pc = pc;
      if_start_signal = 1'b1;
      do @(posedge clk); while (!rdy);
      @(negedge clk);
      if_start_signal = 1'b0;
   endtask

   task automatic pulse_ls(input logic wr, input int n, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      ls_wr = wr;
      ls_size = 3'(n);
      ls_addr = addr;
      ls_wdata = wdata;
      ls_start_signal = 1'b1;
      do @(posedge clk); while (!rdy);
      @(negedge clk);
      ls_start_signal = 1'b0;
   endtask

   task automatic push_ls_exp(input logic wr, input int n, input logic [31:0] addr, input logic [31:0] wdata);
      ls_txn_t t;
      t.is_store = wr;
      t.addr = addr;
      t.n = n;
      t.data = '0;
      if (wr) begin
         for (int i = 0; i < n; i++) begin
            t.data[8*i +: 8] = wdata[8*i +: 8];
            ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
         end
      end else begin
         t.data = ref_load(addr, n);
      end
      ls_q.push_back(t);
   endtask

   task automatic issue_fetch(input logic [31:0] pc);
      if_q.push_back(ref_load(pc, 4));
      pulse_if(pc);
   endtask

   task automatic issue_ls(input logic wr, input int n, input logic [31:0] addr, input logic [31:0] wdata);
      push_ls_exp(wr, n, addr, wdata);
      pulse_ls(wr, n, addr, wdata);
   endtask

   task automatic wait_if_done(input int budget);
      int c = 0;
      while (if_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_output("if_done_in_time", 32'(if_q.size()), 0);
      if_q.delete();
   endtask

   task automatic wait_ls_done(input int budget);
      int c = 0;
      while (ls_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_output("ls_done_in_time", 32'(ls_q.size()), 0);
      ls_q.delete();
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat, il, ll, nwr, base;
      bit wr_seen, fdone, ldone;
      logic [31:0] wd;

      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      if_start_signal = 1'b0; if_pc = '0;
      ls_start_signal = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h00); preload(32'h103, 8'h00);
      preload(32'h202, 8'h00); preload(32'h203, 8'h00);

      #2 rst = 1'b1;
      #1;
      check_output("rst_if_finish", 32'(if_finish_signal), 0);
      check_output("rst_ls_finish", 32'(ls_finish_signal), 0);
      check_output("rst_if_inst", if_inst, 0);
      check_output("rst_ls_rdata", ls_rdata, 0);
      check_output("rst_mem_a", mem_a, 0);
      check_output("rst_mem_dout", 32'(mem_dout), 0);
      check_output("rst_mem_wr", 32'(mem_wr), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // plain fetch: six edges from selection-edge predecessor to finish
      if_q.push_back(ref_load(32'h100, 4));
      pulse_if(32'h100);
      lat = 0; wr_seen = 0;
      while (!if_finish_signal && lat < 20) begin
         @(negedge clk);
         lat++;
         if (mem_wr) wr_seen = 1;
      end
      check_output("fetch_latency", 32'(lat), 6);
      check_output("fetch_no_write", 32'(wr_seen), 0);
      check_output("fetch_word", if_inst, 32'h00000513);
      wait_if_done(5);

      // half-word store, then word load over it
      wd = 32'hDEADBEEF;
      issue_ls(1'b1, 2, 32'h200, wd);
      nwr = 0;
      repeat (8) begin
         @(negedge clk);
         if (mem_wr) begin
            check_output("st_addr", mem_a, 32'h200 + 32'(nwr));
            check_output("st_byte", 32'(mem_dout), 32'(wd[8*nwr +: 8]));
            nwr++;
         end
      end
      check_output("st_write_cycles", 32'(nwr), 2);
      wait_ls_done(10);
      issue_ls(1'b0, 4, 32'h200, 32'h0);
      wait_ls_done(20);
      check_output("ld_after_st", ls_rdata, 32'h0000BEEF);

      // simultaneous requests: LSB first, fetch right behind it
      push_ls_exp(1'b0, 4, 32'h204, 32'h0);
      if_q.push_back(ref_load(32'h104, 4));
      @(negedge clk);
      ls_wr = 1'b0; ls_size = 3'd4; ls_addr = 32'h204; ls_start_signal = 1'b1;
      if_pc = 32'h104; if_start_signal = 1'b1;
      @(negedge clk);
      ls_start_signal = 1'b0; if_start_signal = 1'b0;
      lat = 0; il = 0; ll = 0;
      while ((il == 0 || ll == 0) && lat < 30) begin
         @(negedge clk);
         lat++;
         if (ls_finish_signal && ll == 0) ll = lat;
         if (if_finish_signal && il == 0) il = lat;
      end
      check_output("simul_ls_latency", 32'(ll), 6);
      check_output("simul_if_latency", 32'(il), 12);
      wait_if_done(5);
      wait_ls_done(5);

      // IO store held while the UART buffer is full; a fetch slips through
      io_buffer_full = 1'b1;
      push_ls_exp(1'b1, 1, 32'h00030000, 32'h41);
      pulse_ls(1'b1, 1, 32'h00030000, 32'h41);
      issue_fetch(32'h1000);
      wr_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (mem_wr) wr_seen = 1;
      end
      check_output("io_stall_no_write", 32'(wr_seen), 0);
      check_output("fetch_during_stall", 32'(if_q.size()), 0);
      check_output("io_store_held", 32'(ls_q.size()), 1);
      io_buffer_full = 1'b0;
      lat = 0; nwr = 0;
      while (!ls_finish_signal && lat < 20) begin
         @(negedge clk);
         lat++;
         if (mem_wr) nwr++;
      end
      check_output("io_store_latency", 32'(lat), 2);
      check_output("io_store_writes", 32'(nwr), 1);
      wait_ls_done(5);

      // rollback two cycles into a fetch kills it
      if_q.push_back(ref_load(32'h100, 4));
      base = if_pulses;
      pulse_if(32'h100);
      @(negedge clk);
      @(negedge clk);
      void'(if_q.pop_back());
      rollback = 1'b1;
      @(negedge clk);
      rollback = 1'b0;
      repeat (10) @(negedge clk);
      check_output("rollback_no_finish", 32'(if_pulses - base), 0);
      issue_fetch(32'h104);
      wait_if_done(20);

      // async reset in the middle of a word store
      pulse_ls(1'b1, 4, 32'h3000, 32'h11223344);
      @(negedge clk);
      check_output("wr_before_rst", 32'(mem_wr), 1);
      base = ls_pulses;
      #2 rst = 1'b1;
      #1;
      check_output("rst_mid_mem_wr", 32'(mem_wr), 0);
      check_output("rst_mid_ls_finish", 32'(ls_finish_signal), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_output("rst_no_finish", 32'(ls_pulses - base), 0);
      issue_ls(1'b0, 2, 32'h210, 32'h0);
      wait_ls_done(20);

      // randomized traffic with rdy stalls and a flickering IO buffer
      fdone = 0; ldone = 0;
      fork
         begin
            logic [31:0] pc;
            for (int i = 0; i < 25; i++) begin
               if (i % 8 == 7) pc = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
               else            pc = 32'h1000 + 32'($urandom_range(0, 255));
               issue_fetch(pc);
               wait_if_done(200);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            fdone = 1;
         end
         begin
            int kind, n;
            logic [31:0] a;
            for (int i = 0; i < 40; i++) begin
               kind = $urandom_range(0, 9);
               case ($urandom_range(0, 2))
                  0:       n = 1;
                  1:       n = 2;
                  default: n = 4;
               endcase
               if (kind == 4) begin
                  a = 32'h00030000 + 32'($urandom_range(0, 15));
                  issue_ls(1'b1, n, a, $urandom);
               end else begin
                  a = 32'h2000 + 32'($urandom_range(0, 63));
                  issue_ls(kind < 4, n, a, $urandom);
               end
               wait_ls_done(300);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            ldone = 1;
         end
         begin
            while (!(fdone && ldone)) begin
               @(negedge clk);
               rdy = ($urandom_range(0, 5) != 0);
               io_buffer_full = 1'($urandom_range(0, 1));
            end
            rdy = 1'b1;
            io_buffer_full = 1'b0;
         end
      join

      repeat (5) @(negedge clk);
      check_output("final_if_queue", 32'(if_q.size()), 0);
      check_output("final_ls_queue", 32'(ls_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
